// File: rtl/core_result_collector.sv
// core_result_collector
// Scans the per-core result buffers one core per cycle and captures each
// flagged core exactly once into a small FIFO. The FIFO drains through a
// valid/ready stream. The block also tracks the minimum val_1 result and
// signals completion once every core has been captured and drained.
module core_result_collector #(
  parameter int NUM_CORES  = 61,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 6
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        clear,
  input  logic [NUM_CORES*DATA_W-1:0] buf_val_1_s,
  input  logic [NUM_CORES*DATA_W-1:0] buf_val_2_s,
  input  logic [NUM_CORES-1:0]        buf_flag_s,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ID_W-1:0]             out_core_id,
  output logic [DATA_W-1:0]           out_val_1,
  output logic [DATA_W-1:0]           out_val_2,
  output logic                        best_valid,
  output logic [ID_W-1:0]             best_core_id,
  output logic [DATA_W-1:0]           best_val_1,
  output logic [ID_W:0]               collected,
  output logic                        all_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_CORES - 1);
  localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [ID_W:0]   ALL_CORES = (ID_W + 1)'(NUM_CORES);

  // Flattened buses viewed as per-core arrays for pointer indexing
  logic [DATA_W-1:0] val_1_arr [NUM_CORES];
  logic [DATA_W-1:0] val_2_arr [NUM_CORES];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
    assign val_1_arr[i] = buf_val_1_s[DATA_W*i +: DATA_W];
    assign val_2_arr[i] = buf_val_2_s[DATA_W*i +: DATA_W];
  end

  // Wrap at the last real core, not at the top of the ID_W range
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
    return (p == LAST_ID) ? '0 : p + ID_W'(1);
  endfunction

  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [NUM_CORES-1:0] taken_q, taken_d;
  logic [AW-1:0]        wr_q, wr_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic [CW-1:0]        count_q, count_d;
  logic [ID_W:0]        collected_q, collected_d;
  logic                 best_valid_q, best_valid_d;
  logic [ID_W-1:0]      best_id_q, best_id_d;
  logic [DATA_W-1:0]    best_v1_q, best_v1_d;

  logic [ID_W-1:0]      id_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]    v1_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]    v2_mem [FIFO_DEPTH];

  logic              cand;
  logic              full;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] cur_v1;
  logic [DATA_W-1:0] cur_v2;

  // Push uses the count at the start of the cycle, so a same-cycle pop
  // never makes room for a capture.
  assign cand   = buf_flag_s[ptr_q] && !taken_q[ptr_q];
  assign full   = (count_q == FULL_CNT);
  assign push   = cand && !full;
  assign pop    = out_valid && out_ready;
  assign cur_v1 = val_1_arr[ptr_q];
  assign cur_v2 = val_2_arr[ptr_q];

  // Next-state for scan pointer, capture mask, FIFO control and best tracking
  always_comb begin
    ptr_d        = ptr_q;
    taken_d      = taken_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    count_d      = count_q;
    collected_d  = collected_q;
    best_valid_d = best_valid_q;
    best_id_d    = best_id_q;
    best_v1_d    = best_v1_q;
    if (clear) begin
      ptr_d        = '0;
      taken_d      = '0;
      wr_d         = '0;
      rd_d         = '0;
      count_d      = '0;
      collected_d  = '0;
      best_valid_d = 1'b0;
      best_id_d    = '0;
      best_v1_d    = '0;
    end else begin
      // Hold the pointer on a core whose capture is blocked by a full FIFO
      if (!(cand && full)) ptr_d = next_ptr(ptr_q);
      if (push) begin
        wr_d           = wr_q + AW'(1);
        taken_d[ptr_q] = 1'b1;
        collected_d    = collected_q + (ID_W + 1)'(1);
        if (!best_valid_q || (cur_v1 < best_v1_q)) begin
          best_valid_d = 1'b1;
          best_id_d    = ptr_q;
          best_v1_d    = cur_v1;
        end
      end
      if (pop) rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and result-tracking state registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ptr_q        <= '0;
      taken_q      <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      collected_q  <= '0;
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      best_v1_q    <= '0;
    end else begin
      ptr_q        <= ptr_d;
      taken_q      <= taken_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      collected_q  <= collected_d;
      best_valid_q <= best_valid_d;
      best_id_q    <= best_id_d;
      best_v1_q    <= best_v1_d;
    end
  end

  // FIFO storage; contents are only visible while count is non-zero
  always_ff @(posedge Clk) begin
    if (push) begin
      id_mem[wr_q] <= ptr_q;
      v1_mem[wr_q] <= cur_v1;
      v2_mem[wr_q] <= cur_v2;
    end
  end

  // Head data is forced to zero when empty so reset/clear yield zero outputs
  assign out_valid    = (count_q != '0);
  assign out_core_id  = out_valid ? id_mem[rd_q] : '0;
  assign out_val_1    = out_valid ? v1_mem[rd_q] : '0;
  assign out_val_2    = out_valid ? v2_mem[rd_q] : '0;
  assign best_valid   = best_valid_q;
  assign best_core_id = best_id_q;
  assign best_val_1   = best_v1_q;
  assign collected    = collected_q;
  assign all_done     = (collected_q == ALL_CORES) && (count_q == '0);

endmodule

// File: tb/tb_core_result_collector.sv
// Directed testbench for core_result_collector.
module tb_core_result_collector;

  localparam int NC = 61;
  localparam int DW = 32;
  localparam int FD = 4;
  localparam int IW = 6;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              clear;
  logic [NC*DW-1:0]  v1_s;
  logic [NC*DW-1:0]  v2_s;
  logic [NC-1:0]     flag_s;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     out_core_id;
  logic [DW-1:0]     out_val_1;
  logic [DW-1:0]     out_val_2;
  logic              best_valid;
  logic [IW-1:0]     best_core_id;
  logic [DW-1:0]     best_val_1;
  logic [IW:0]       collected;
  logic              all_done;

  int checks   = 0;
  int failures = 0;

  core_result_collector #(
    .NUM_CORES (NC),
    .DATA_W    (DW),
    .FIFO_DEPTH(FD),
    .ID_W      (IW)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .clear       (clear),
    .buf_val_1_s (v1_s),
    .buf_val_2_s (v2_s),
    .buf_flag_s  (flag_s),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_core_id (out_core_id),
    .out_val_1   (out_val_1),
    .out_val_2   (out_val_2),
    .best_valid  (best_valid),
    .best_core_id(best_core_id),
    .best_val_1  (best_val_1),
    .collected   (collected),
    .all_done    (all_done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: through the rising edge, then settle on the falling edge
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic load_pattern();
    for (int i = 0; i < NC; i++) begin
      flag_s[i]          = 1'b1;
      v1_s[DW*i +: DW]   = 32'(100 - i);
      v2_s[DW*i +: DW]   = 32'(32'h1000 + i);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Drains the stream with out_ready high, expecting ids start..NC-1 in order
  task automatic drain_check(input string tag, input int start);
    int n   = start;
    int cyc = 0;
    int bad = 0;
    while (n < NC && cyc < 2000) begin
      if (out_valid) begin
        if (out_core_id !== IW'(n) || out_val_1 !== 32'(100 - n) ||
            out_val_2 !== 32'(32'h1000 + n)) bad++;
        n++;
      end
      step();
      cyc++;
    end
    check({tag, "_beats"}, 64'(n), 64'(NC));
    check({tag, "_order_errs"}, 64'(bad), 64'd0);
    check({tag, "_best_id"}, best_core_id, 64'd60);
    check({tag, "_best_v1"}, best_val_1, 64'd40);
    check({tag, "_collected"}, collected, 64'd61);
    check({tag, "_all_done"}, all_done, 64'd1);
    check({tag, "_empty"}, out_valid, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int extra;

    Reset     = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    flag_s    = '0;
    v1_s      = '0;
    v2_s      = '0;

    // Test 1: reset state and idle running
    #2;
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_collected", collected, 64'd0);
    check("rst_all_done", all_done, 64'd0);
    check("rst_best_valid", best_valid, 64'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (200) step();
    check("idle_out_valid", out_valid, 64'd0);
    check("idle_collected", collected, 64'd0);
    check("idle_all_done", all_done, 64'd0);

    // Test 2: single flagged core, captured once
    flag_s[5]       = 1'b1;
    v1_s[DW*5 +: DW] = 32'h10;
    v2_s[DW*5 +: DW] = 32'hAB;
    out_ready       = 1'b1;
    waited = 0;
    while (!out_valid && waited < 80) begin
      step();
      waited++;
    end
    check("t2_valid", out_valid, 64'd1);
    check("t2_id", out_core_id, 64'd5);
    check("t2_v1", out_val_1, 64'h10);
    check("t2_v2", out_val_2, 64'hAB);
    step();
    check("t2_popped", out_valid, 64'd0);
    extra = 0;
    for (int c = 0; c < 200; c++) begin
      if (out_valid) extra++;
      step();
    end
    check("t2_no_repeat", 64'(extra), 64'd0);
    check("t2_collected", collected, 64'd1);
    check("t2_best_id", best_core_id, 64'd5);
    check("t2_best_v1", best_val_1, 64'h10);
    check("t2_best_valid", best_valid, 64'd1);
    check("t2_all_done", all_done, 64'd0);

    // Test 3 + 5: all flags, stall on full FIFO, then drain in id order
    load_pattern();
    out_ready = 1'b0;
    pulse_clear();
    check("clr_collected", collected, 64'd0);
    check("clr_best_valid", best_valid, 64'd0);
    repeat (10) step();
    check("t3_full_collected", collected, 64'd4);
    check("t3_head_id", out_core_id, 64'd0);
    check("t3_head_v1", out_val_1, 64'd100);
    out_ready = 1'b1;
    step();
    check("t5_no_push_on_pop", collected, 64'd4);
    check("t5_head_id1", out_core_id, 64'd1);
    step();
    check("t5_push_next", collected, 64'd5);
    check("t5_head_id2", out_core_id, 64'd2);
    drain_check("t3", 2);

    // Test 4: tie on minimum keeps the earlier capture
    for (int i = 0; i < NC; i++) v1_s[DW*i +: DW] = 32'd50;
    v1_s[DW*3 +: DW] = 32'd7;
    v1_s[DW*9 +: DW] = 32'd7;
    pulse_clear();
    repeat (150) step();
    check("t4_best_id", best_core_id, 64'd3);
    check("t4_best_v1", best_val_1, 64'd7);
    check("t4_all_done", all_done, 64'd1);

    // Test 6a: asynchronous reset mid-drain, then full re-collection
    load_pattern();
    out_ready = 1'b0;
    pulse_clear();
    repeat (10) step();
    out_ready = 1'b1;
    repeat (5) step();
    #2;
    Reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 64'd0);
    check("arst_out_id", out_core_id, 64'd0);
    check("arst_out_v1", out_val_1, 64'd0);
    check("arst_out_v2", out_val_2, 64'd0);
    check("arst_collected", collected, 64'd0);
    check("arst_best_valid", best_valid, 64'd0);
    check("arst_best_v1", best_val_1, 64'd0);
    check("arst_all_done", all_done, 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    drain_check("t6rst", 0);

    // Test 6b: same sequence restarted with clear
    out_ready = 1'b0;
    pulse_clear();
    repeat (10) step();
    out_ready = 1'b1;
    repeat (5) step();
    pulse_clear();
    check("sclr_out_valid", out_valid, 64'd0);
    check("sclr_collected", collected, 64'd0);
    check("sclr_all_done", all_done, 64'd0);
    drain_check("t6clr", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
